// File: rtl/bus_memory_responder.sv
// Bus responder backing an address window with a word-addressed RAM; bus outputs are 0 unless a transaction is owned.
// States: IDLE wait begin | READ_LAUNCH first RAM read | READ_DATA stream words | WRITE accept words | END end pulse | ERROR overrun pulse
module bus_memory_responder #(
    parameter logic [31:0] BASE_ADDRESS  = 32'h0000_0000,
    parameter int          SIZE_IN_WORDS = 512
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dataIN,
    input  logic [3:0]  byte_enableIN,
    input  logic [7:0]  burst_sizeIN,
    input  logic        read_n_writeIN,
    input  logic        begin_transactionIN,
    input  logic        end_transactionIN,
    input  logic        data_validIN,
    input  logic        busyIN,
    output logic [31:0] address_dataOUT,
    output logic        end_transactionOUT,
    output logic        data_validOUT,
    output logic        busyOUT,
    output logic        errorOUT
);

    localparam int ADDR_BITS = $clog2(SIZE_IN_WORDS);
    localparam int SUM_BITS  = ADDR_BITS + 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_LAUNCH,
        S_READ_DATA,
        S_WRITE,
        S_END,
        S_ERROR
    } state_t;

    logic [31:0]          r_mem [SIZE_IN_WORDS];
    state_t               r_state;
    logic [ADDR_BITS-1:0] r_ptr;
    logic [7:0]           r_burst;
    logic [8:0]           r_cnt;
    logic [3:0]           r_be;
    logic [31:0]          r_dout;
    logic                 r_dv;
    logic                 r_end;
    logic                 r_err;

    logic                 w_in_window;
    logic [ADDR_BITS-1:0] w_index;
    logic [SUM_BITS-1:0]  w_span;
    logic                 w_overrun;
    logic                 w_last;
    logic                 w_we;

    assign w_in_window = (address_dataIN[31:ADDR_BITS+2] == BASE_ADDRESS[31:ADDR_BITS+2]);
    assign w_index     = address_dataIN[ADDR_BITS+1:2];
    assign w_span      = SUM_BITS'(w_index) + SUM_BITS'(burst_sizeIN);
    assign w_overrun   = (w_span > SUM_BITS'(SIZE_IN_WORDS - 1));
    assign w_last      = (r_cnt == {1'b0, r_burst});
    // Words beyond the promised burst length are silently dropped.
    assign w_we        = (r_state == S_WRITE) && data_validIN && (r_cnt <= {1'b0, r_burst}) && !reset;

    always_ff @(posedge clock) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (r_be[b]) begin
                    r_mem[r_ptr][8*b +: 8] <= address_dataIN[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            r_be    <= '0;
            r_dout  <= '0;
            r_dv    <= 1'b0;
            r_end   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (begin_transactionIN && w_in_window) begin
                        r_ptr   <= w_index;
                        r_burst <= burst_sizeIN;
                        r_be    <= byte_enableIN;
                        r_cnt   <= '0;
                        if (w_overrun) begin
                            r_state <= S_ERROR;
                            r_err   <= 1'b1;
                            r_end   <= 1'b1;
                        end else if (read_n_writeIN) begin
                            r_state <= S_READ_LAUNCH;
                        end else begin
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_READ_LAUNCH: begin
                    r_dout  <= r_mem[r_ptr];
                    r_dv    <= 1'b1;
                    r_ptr   <= r_ptr + 1'b1;
                    r_state <= S_READ_DATA;
                end
                S_READ_DATA: begin
                    // The output register doubles as the skid stage: it only advances on acceptance.
                    if (!busyIN) begin
                        if (w_last) begin
                            r_dout  <= '0;
                            r_dv    <= 1'b0;
                            r_end   <= 1'b1;
                            r_state <= S_END;
                        end else begin
                            r_dout <= r_mem[r_ptr];
                            r_ptr  <= r_ptr + 1'b1;
                            r_cnt  <= r_cnt + 9'd1;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_we) begin
                        r_ptr <= r_ptr + 1'b1;
                        r_cnt <= r_cnt + 9'd1;
                    end
                    if (end_transactionIN) begin
                        r_state <= S_IDLE;
                    end
                end
                S_END: begin
                    r_end   <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_ERROR: begin
                    r_err   <= 1'b0;
                    r_end   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign address_dataOUT    = r_dout;
    assign data_validOUT      = r_dv;
    assign end_transactionOUT = r_end;
    assign errorOUT           = r_err;
    assign busyOUT            = 1'b0;

endmodule

// File: doc/bus_memory_responder.md
# bus_memory_responder

Bus responder (slave) for the system bus used by the JTAG DMA initiator. It sits on the system-clock side and backs an address window with a word-addressed on-chip RAM. It serves single and burst reads and writes issued by any initiator, including the JTAG DMA, so that the JTAG path can be exercised end-to-end without external memory. It only drives its bus outputs while it owns a transaction; at all other times they are 0, which makes them safe to OR onto a shared bus.

## Interface
Parameters:
- BASE_ADDRESS, 32'h0000_0000: byte base of the window. Must be aligned to 4*SIZE_IN_WORDS.
- SIZE_IN_WORDS, 512: RAM depth. Must be a power of two, at least 2. ADDR_BITS = log2(SIZE_IN_WORDS).

Ports (clock and reset first):
- clock  in  1  system clock; one clock domain, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- address_dataIN  in  32  address at begin, write data afterwards.
- byte_enableIN  in  4  byte lanes; sampled at begin, applied to every word of the burst.
- burst_sizeIN  in  8  number of words minus 1.
- read_n_writeIN  in  1  1 = read, 0 = write.
- begin_transactionIN  in  1  single-cycle transaction start.
- end_transactionIN  in  1  initiator ends a write.
- data_validIN  in  1  write word present on address_dataIN.
- busyIN  in  1  initiator stalls read data.
- address_dataOUT  out  32  read data; 0 when not valid.
- end_transactionOUT  out  1  responder ends a read or an error.
- data_validOUT  out  1  read word present.
- busyOUT  out  1  constant 0; the responder never stalls writes.
- errorOUT  out  1  burst overrun.

## Operation
- States: IDLE, READ_LAUNCH, READ_DATA, WRITE, END, ERROR.
- Window select, in IDLE only, when begin_transactionIN=1 and address_dataIN[31:ADDR_BITS+2] == BASE_ADDRESS[31:ADDR_BITS+2].
  - Address bits [1:0] are ignored.
  - Word index = address_dataIN[ADDR_BITS+1:2].
  - A begin outside the window is ignored and no output changes.
- On select, the block captures the word index, burst_sizeIN, byte_enableIN and read_n_writeIN.
- Overrun check: if index + burst_size > SIZE_IN_WORDS-1 (computed at ADDR_BITS+9 bits wide, no wrap), go to ERROR.
  - ERROR asserts errorOUT=1 and end_transactionOUT=1 for exactly one cycle, then returns to IDLE.
  - No RAM access takes place.
- Otherwise, a read goes to READ_LAUNCH and a write goes to WRITE.
- Read path: READ_LAUNCH → READ_DATA.
  - Words are presented in ascending order.
  - A word counts as accepted on a cycle with data_validOUT=1 and busyIN=0.
  - While busyIN=1, address_dataOUT and data_validOUT hold their values.
  - After word burst_size+1 is accepted, go to END, which drives end_transactionOUT=1 for one cycle, then IDLE.
- Write path: in WRITE, each cycle with data_validIN=1 writes address_dataIN to the current word and increments the word pointer.
  - Only lanes with byte_enableIN=1 (as captured at begin) are written; the other bytes keep their value.
  - data_validIN words after burst_size+1 are dropped.
  - end_transactionIN=1 returns to IDLE on that edge. A data_validIN in the same cycle is still written.
  - An early end (fewer words than promised) is legal; the remaining words are untouched.
- begin_transactionIN outside IDLE is ignored.
- end_transactionIN outside WRITE is ignored.
- reset (any state): go to IDLE, all outputs 0, counters cleared. RAM contents are kept.

## Timing
- Reset values: address_dataOUT=0, end_transactionOUT=0, data_validOUT=0, busyOUT=0, errorOUT=0.
- Cycle 0 is the cycle in which begin_transactionIN is sampled.
- Error: errorOUT and end_transactionOUT are high in cycle 1 only. A new begin is accepted from cycle 2.
- Read of N = burst_size+1 words with busyIN=0 throughout:
  - data_validOUT high in cycles 2..N+1.
  - One word per cycle, with no bubbles between words (prefetch/skid internally around the synchronous RAM read).
  - end_transactionOUT high in cycle N+2.
  - A new begin is accepted from cycle N+3.
- Each busyIN stall cycle delays all later events by one cycle.
- Write: word i is visible to a read that begins on the cycle after end_transactionIN.
- busyOUT is 0 in every cycle.

## Test plan
- Reset, then idle 10 cycles → all outputs 0; a begin at BASE_ADDRESS+4*SIZE_IN_WORDS gets no response.
- Write 32'hDEADBEEF at BASE+8 (burst 0, be=4'hF, end together with the word), then read BASE+8 burst 0 → data_validOUT in cycle 2 with 32'hDEADBEEF, end_transactionOUT in cycle 3.
- Write 32'h12345678 at BASE+8 with be=4'b0011 → a read returns 32'hDEAD5678.
- Write 4 words 1,2,3,4 at BASE+0x100, then read burst 3 with busyIN=1 in cycles 3–4 → words 1,2,2,2,3,4 appear on data_validOUT cycles 2–7 (word 2 held during the stall), end in cycle 8.
- Begin at word SIZE_IN_WORDS-1 with burst 1 → errorOUT=end_transactionOUT=1 in cycle 1 only; the last word is unchanged.
- Assert reset during cycle 3 of a burst-7 read → outputs 0 the next cycle; a following read returns the stored data intact.
